pipe_reg_ex_mem_skid: RTL and testbench

- Parametrised EX/MEM pipeline register for the segmented RISC-V core, replacing the bare EX/MEM latch.
- Captures the EX-stage payload plus the M and WB control bundles.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble gating of control bits, a forwarding tap and a saturating stall counter.
- Sits between the ALU encapsulator/branch adder (EX) and data memory (MEM).

---
 rtl/riscv_pipe_pkg.sv | 35 +++
 rtl/pipe_skid_buffer.sv | 81 ++++++++
 rtl/pipe_reg_ex_mem_skid.sv | 78 +++++++
 tb/tb_pipe_reg_ex_mem_skid.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the segmented RISC-V pipeline registers.
package riscv_pipe_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int FUNC3_W_DEF    = 3;

  typedef struct packed {
    logic jump_pc;
    logic instruction_func;
    logic force_jump;
    logic branch;
    logic mem_write;
    logic mem_read;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic jump_rd;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0]       adder_sum;
    logic [XLEN_DEF-1:0]       alu_result;
    logic                      alu_zero;
    logic [XLEN_DEF-1:0]       read_data_2;
    logic [FUNC3_W_DEF-1:0]    func3;
    logic [REG_ADDR_W_DEF-1:0] rd;
  } ex_mem_payload_t;

  localparam m_ctrl_t  M_CTRL_NOP  = '0;
  localparam wb_ctrl_t WB_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic valid/ready register with optional 2-entry skid and sync flush; 1-cycle latency.
// Backpressure: with skid, in_ready depends only on held state; without, in_ready follows out_ready.
module pipe_skid_buffer #(
  parameter int                DATA_W   = 8,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLR_MASK = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              accept;
  logic              xfer;

  assign accept    = in_valid && in_ready && !flush;
  assign xfer      = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  generate
    if (SKID_EN) begin : g_skid
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;

      assign in_ready = rst_n && !skid_valid;

      // Skid only fills when main is held, so it always drains into main first.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_data  <= main_data & ~CLR_MASK;
          skid_data  <= skid_data & ~CLR_MASK;
        end else if (skid_valid && xfer) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept && (!main_valid || xfer)) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else if (accept) begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
        end else if (xfer) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_noskid
      assign in_ready = rst_n && (out_ready || !main_valid);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= main_data & ~CLR_MASK;
        end else if (accept) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else if (xfer) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_reg_ex_mem_skid.sv
// EX/MEM pipeline register: payload + M/WB control, forwarding tap, stall counter; 1-cycle latency.
// Backpressure: 2-entry skid absorbs one extra beat; in_ready is not combinational on out_ready.
module pipe_reg_ex_mem_skid
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int FUNC3_W    = FUNC3_W_DEF,
  parameter bit SKID_EN    = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  ex_mem_payload_t       in_payload,
  input  m_ctrl_t               in_m,
  input  wb_ctrl_t              in_wb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output ex_mem_payload_t       out_payload,
  output m_ctrl_t               out_m,
  output wb_ctrl_t              out_wb,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_value,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PAYLOAD_W = 3 * XLEN + 1 + FUNC3_W + REG_ADDR_W;
  localparam int CTRL_W    = $bits(m_ctrl_t) + $bits(wb_ctrl_t);
  localparam int DATA_W    = PAYLOAD_W + CTRL_W;
  // Control bits sit in the low slice so flush can clear them without touching data.
  localparam logic [DATA_W-1:0] CTRL_MASK = {{PAYLOAD_W{1'b0}}, {CTRL_W{1'b1}}};

  logic [DATA_W-1:0]    buf_in;
  logic [DATA_W-1:0]    buf_out;
  logic [PAYLOAD_W-1:0] held_payload;
  m_ctrl_t              held_m;
  wb_ctrl_t             held_wb;

  assign buf_in = {in_payload, in_m, in_wb};
  assign {held_payload, held_m, held_wb} = buf_out;

  pipe_skid_buffer #(
    .DATA_W  (DATA_W),
    .SKID_EN (SKID_EN),
    .CLR_MASK(CTRL_MASK)
  ) u_buf (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_payload = held_payload;
  assign out_m       = out_valid ? held_m  : M_CTRL_NOP;
  assign out_wb      = out_valid ? held_wb : WB_CTRL_NOP;

  assign fwd_valid = out_valid && out_wb.reg_write && (out_payload.rd != '0);
  assign fwd_rd    = out_payload.rd;
  assign fwd_value = out_payload.alu_result;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_ex_mem_skid.sv
// Directed bench for the EX/MEM skid register (CNT_W=4 so saturation is reachable).
module tb_pipe_reg_ex_mem_skid;
  import riscv_pipe_pkg::*;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  ex_mem_payload_t in_payload = '0;
  m_ctrl_t         in_m = '0;
  wb_ctrl_t        in_wb = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  ex_mem_payload_t out_payload;
  m_ctrl_t         out_m;
  wb_ctrl_t        out_wb;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [31:0]     fwd_value;
  logic [3:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_reg_ex_mem_skid #(.CNT_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_m(in_m), .in_wb(in_wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_m(out_m), .out_wb(out_wb),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_value(fwd_value),
    .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] v, input logic [4:0] rd);
    in_valid              = 1'b1;
    in_payload            = '0;
    in_payload.alu_result = v;
    in_payload.adder_sum  = v + 32'h4;
    in_payload.func3      = 3'b010;
    in_payload.rd         = rd;
    in_m                  = '0;
    in_m.mem_write        = 1'b1;
    in_wb                 = '0;
    in_wb.reg_write       = 1'b1;
  endtask

  task automatic do_reset();
    RESET_N   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cyc%0d got %b want 0", i, in_ready); end
    end
    RESET_N = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_m !== M_CTRL_NOP || out_wb !== WB_CTRL_NOP) begin
      errors++; $display("FAIL reset_ctrl got m=%h wb=%h want 0", out_m, out_wb);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [4];
    vals = '{32'h10, 32'h20, 32'h30, 32'h40};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_beat(vals[k], 5'd1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_payload.alu_result !== vals[k] || out_m.mem_write !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat%0d got v=%b alu=%h mw=%b want v=1 alu=%h mw=1",
                 k, out_valid, out_payload.alu_result, out_m.mem_write, vals[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid); end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'hA1, 5'd2);
    tick();
    drive_beat(32'hA2, 5'd2);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_payload.alu_result !== 32'hA1) begin
      errors++; $display("FAIL bp_full got rdy=%b alu=%h want rdy=0 alu=a1", in_ready, out_payload.alu_result);
    end
    drive_beat(32'hA3, 5'd2);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_payload.alu_result !== 32'hA1) begin
      errors++; $display("FAIL bp_hold got rdy=%b v=%b alu=%h want rdy=0 v=1 alu=a1",
                         in_ready, out_valid, out_payload.alu_result);
    end
    checks++;
    if (stall_cnt !== 4'd3) begin errors++; $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_payload.alu_result !== 32'hA2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b alu=%h rdy=%b want v=1 alu=a2 rdy=1",
                         out_valid, out_payload.alu_result, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_payload.alu_result !== 32'hA3) begin
      errors++; $display("FAIL bp_third got v=%b alu=%h want v=1 alu=a3", out_valid, out_payload.alu_result);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
      errors++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=3", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'hB1, 5'd3);
    tick();
    drive_beat(32'hB2, 5'd3);
    tick();
    drive_beat(32'hB3, 5'd3);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_m.mem_write !== 1'b0 || out_wb.reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_out got v=%b mw=%b rw=%b want 0 0 0", out_valid, out_m.mem_write, out_wb.reg_write);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL flush_stall got %0d want 1", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost_beat got %b want 0", out_valid); end
  endtask

  task automatic test_forwarding();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'hDEAD, 5'd5);
    tick();
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_value !== 32'hDEAD) begin
      errors++; $display("FAIL fwd_rd5 got v=%b rd=%0d val=%h want 1 5 dead", fwd_valid, fwd_rd, fwd_value);
    end
    out_ready = 1'b1;
    drive_beat(32'hDEAD, 5'd0);
    tick();
    checks++;
    if (fwd_valid !== 1'b0 || out_valid !== 1'b1 || fwd_value !== 32'hDEAD) begin
      errors++; $display("FAIL fwd_rd0 got fv=%b ov=%b val=%h want 0 1 dead", fwd_valid, out_valid, fwd_value);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'h55, 5'd7);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (k > 15) ? 15 : k;
      checks++;
      if (stall_cnt !== exp_cnt[3:0] || out_valid !== 1'b1) begin
        errors++; $display("FAIL sat_cyc%0d got cnt=%0d v=%b want cnt=%0d v=1", k, stall_cnt, out_valid, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_forwarding();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
